// File: rtl/dpi_dfa_pkg.sv
// Shared constants for the table-driven DFA matcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpi_dfa_pkg;

   localparam logic [1:0] CFG_SEL_CMAP  = 2'd0;
   localparam logic [1:0] CFG_SEL_TRANS = 2'd1;
   localparam logic [1:0] CFG_SEL_ACC   = 2'd2;

   localparam int DFA_STATE_W    = 11;
   localparam int DFA_NUM_STATES = 16;
   localparam int DFA_CLASS_W    = 4;
   localparam int DFA_FLOW_W     = 3;
   localparam int DFA_CNT_W      = 16;

   localparam int CFG_ADDR_W  = 12;
   // Transition rows are always strided by 16 classes so the config address
   // {state[7:0], class[3:0]} is also the table index.
   localparam int TRANS_CLS_W = 4;

   function automatic logic [CFG_ADDR_W-1:0] trans_addr(input logic [7:0]             state,
                                                        input logic [TRANS_CLS_W-1:0] cls);
      return {state, cls};
   endfunction

endpackage

// File: rtl/dpi_dfa_table.sv
// Generic DEPTH x WIDTH runtime-loaded table; out-of-range reads return 0.
// Latency: combinational read, write lands at the clock edge.
// Backpressure: none; out-of-range writes are dropped.
module dpi_dfa_table #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 4,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Read returns zero for any address beyond the implemented depth.
   always_comb begin
      rd_data = '0;
      if (rd_addr < AW'(DEPTH)) rd_data = mem_q[rd_addr[IW-1:0]];
   end

   // Single write port; addresses beyond the depth are ignored.
   always_comb begin
      mem_d = mem_q;
      if (wr_en && (wr_addr < AW'(DEPTH))) mem_d[wr_addr[IW-1:0]] = wr_data;
   end

   // Table storage, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
   end

endmodule

// File: rtl/dpi_dfa_multiflow_engine.sv
// Table-driven regex DFA shared across NUM_FLOWS interleaved byte streams.
// Latency: byte accepted in cycle N reports accept_* in cycle N+2; 1 byte/cycle.
// Backpressure: char_rdy drops only while a config write is in progress.
module dpi_dfa_multiflow_engine
   import dpi_dfa_pkg::*;
#(
   parameter int STATE_W    = DFA_STATE_W,
   parameter int NUM_STATES = DFA_NUM_STATES,
   parameter int CLASS_W    = DFA_CLASS_W,
   parameter int FLOW_W     = DFA_FLOW_W,
   parameter int CNT_W      = DFA_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [1:0]            cfg_sel,
   input  logic [CFG_ADDR_W-1:0] cfg_addr,
   input  logic [STATE_W-1:0]    cfg_wdata,
   input  logic [7:0]            char_in,
   input  logic                  char_vld,
   input  logic [FLOW_W-1:0]     char_flow,
   input  logic                  char_last,
   output logic                  char_rdy,
   input  logic                  state_wr_vld,
   input  logic [FLOW_W-1:0]     state_wr_flow,
   input  logic [STATE_W-1:0]    state_wr_data,
   output logic                  accept_vld,
   output logic [FLOW_W-1:0]     accept_flow,
   output logic [STATE_W-1:0]    accept_state,
   input  logic [FLOW_W-1:0]     cnt_rd_flow,
   output logic [CNT_W-1:0]      cnt_rd_data,
   input  logic                  cnt_clr
);

   localparam int NUM_FLOWS   = 2**FLOW_W;
   localparam int TRANS_DEPTH = NUM_STATES * (2**TRANS_CLS_W);

   typedef struct packed {
      logic [CLASS_W-1:0] cls;
      logic [FLOW_W-1:0]  flow;
      logic               last;
   } s1_t;

   s1_t                s1_q, s1_d;
   logic               s1_vld_q, s1_vld_d;
   logic [STATE_W-1:0] ctx_q [NUM_FLOWS];
   logic [STATE_W-1:0] ctx_d [NUM_FLOWS];
   logic [CNT_W-1:0]   cnt_q [NUM_FLOWS];
   logic [CNT_W-1:0]   cnt_d [NUM_FLOWS];
   logic               accept_vld_q, accept_vld_d;
   logic [FLOW_W-1:0]  accept_flow_q, accept_flow_d;
   logic [STATE_W-1:0] accept_state_q, accept_state_d;

   logic               char_fire;
   logic [CLASS_W-1:0] cmap_rd;
   logic [STATE_W-1:0] trans_rd;
   logic [0:0]         acc_rd;
   logic [STATE_W-1:0] cur;
   logic [STATE_W-1:0] nxt;
   logic               cur_live;
   logic               wr_conflict;

   assign char_rdy  = !cfg_we;
   assign char_fire = char_vld && char_rdy;

   dpi_dfa_table #(.DEPTH(256), .WIDTH(CLASS_W), .AW(CFG_ADDR_W)) u_cmap (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cfg_we && (cfg_sel == CFG_SEL_CMAP)),
      .wr_addr (cfg_addr),
      .wr_data (cfg_wdata[CLASS_W-1:0]),
      .rd_addr (CFG_ADDR_W'(char_in)),
      .rd_data (cmap_rd)
   );

   dpi_dfa_table #(.DEPTH(TRANS_DEPTH), .WIDTH(STATE_W), .AW(CFG_ADDR_W)) u_trans (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cfg_we && (cfg_sel == CFG_SEL_TRANS)),
      .wr_addr (cfg_addr),
      .wr_data (cfg_wdata),
      .rd_addr (trans_addr(cur[7:0], TRANS_CLS_W'(s1_q.cls))),
      .rd_data (trans_rd)
   );

   dpi_dfa_table #(.DEPTH(NUM_STATES), .WIDTH(1), .AW(CFG_ADDR_W)) u_acc (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cfg_we && (cfg_sel == CFG_SEL_ACC)),
      .wr_addr (cfg_addr),
      .wr_data (cfg_wdata[0:0]),
      .rd_addr (CFG_ADDR_W'(nxt)),
      .rd_data (acc_rd)
   );

   // S1: classify the incoming byte and capture its flow/last tags.
   always_comb begin
      s1_vld_d = char_fire;
      s1_d     = s1_q;
      if (char_fire) begin
         s1_d.cls  = cmap_rd;
         s1_d.flow = char_flow;
         s1_d.last = char_last;
      end
   end

   // S2: step the flow's DFA context; dead states fall to state 0.
   always_comb begin
      cur         = ctx_q[s1_q.flow];
      cur_live    = cur < STATE_W'(NUM_STATES);
      nxt         = cur_live ? trans_rd : '0;
      wr_conflict = state_wr_vld && (state_wr_flow == s1_q.flow);
   end

   // Context update; an external overwrite beats the pipeline write to the same flow.
   always_comb begin
      ctx_d = ctx_q;
      if (s1_vld_q) ctx_d[s1_q.flow] = s1_q.last ? '0 : nxt;
      if (state_wr_vld) ctx_d[state_wr_flow] = state_wr_data;
   end

   // Match report; suppressed when an external overwrite hits the same flow.
   always_comb begin
      accept_vld_d   = s1_vld_q && acc_rd[0] && !wr_conflict;
      accept_flow_d  = accept_vld_d ? s1_q.flow : '0;
      accept_state_d = accept_vld_d ? nxt : '0;
   end

   // Saturating per-flow match counters; clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '{default: '0};
      end else if (accept_vld_q && (cnt_q[accept_flow_q] != '1)) begin
         cnt_d[accept_flow_q] = cnt_q[accept_flow_q] + CNT_W'(1);
      end
   end

   // Pipeline, context and counter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q           <= '0;
         s1_vld_q       <= 1'b0;
         ctx_q          <= '{default: '0};
         cnt_q          <= '{default: '0};
         accept_vld_q   <= 1'b0;
         accept_flow_q  <= '0;
         accept_state_q <= '0;
      end else begin
         s1_q           <= s1_d;
         s1_vld_q       <= s1_vld_d;
         ctx_q          <= ctx_d;
         cnt_q          <= cnt_d;
         accept_vld_q   <= accept_vld_d;
         accept_flow_q  <= accept_flow_d;
         accept_state_q <= accept_state_d;
      end
   end

   assign accept_vld   = accept_vld_q;
   assign accept_flow  = accept_flow_q;
   assign accept_state = accept_state_q;
   assign cnt_rd_data  = cnt_q[cnt_rd_flow];

endmodule
